// File: rtl/muxn_reg.sv
// Registered N-to-1 operand selector with a 2-entry valid/ready output buffer.
// Define MUX_RR_EN for round-robin grant; otherwise the grant follows sel.
module muxn_reg #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned N     = 4,
   parameter int unsigned SEL_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [SEL_W-1:0]   sel,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_sel,
   output logic               out_valid,
   input  logic               out_ready
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   head_data, tail_data, push_data;
   logic [SEL_W-1:0]   head_sel, tail_sel;
   logic [SEL_W-1:0]   grant;
   logic               grant_vld;
   logic               not_full;
   logic               push, pop;
   logic               load_head, load_tail, shift;

`ifdef MUX_RR_EN
   logic [SEL_W-1:0]   rr_ptr;
   logic               unused_sel;

   assign unused_sel = ^sel;

   // First valid channel at or above the pointer, wrapping modulo N.
   always_comb begin
      grant_vld = 1'b0;
      grant     = '0;
      for (int unsigned k = 0; k < N; k++) begin
         for (int unsigned j = 0; j < N; j++) begin
            if (!grant_vld && j == (32'(rr_ptr) + k) % N && in_valid[j]) begin
               grant_vld = 1'b1;
               grant     = SEL_W'(j);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rr_ptr <= '0;
      else if (push)
         rr_ptr <= SEL_W'((32'(grant) + 1) % N);
   end
`else
   always_comb begin
      grant_vld = (32'(sel) < N);
      grant     = sel;
   end
`endif

   assign not_full = (state_q != TWO);

   always_comb begin
      in_ready  = '0;
      push_data = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant_vld && 32'(grant) == i) begin
            in_ready[i] = not_full;
            push_data   = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign push      = |(in_valid & in_ready);
   assign out_valid = (state_q != EMPTY);
   assign pop       = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (push) state_d = ONE;
         ONE: begin
            if (push && !pop)
               state_d = TWO;
            else if (!push && pop)
               state_d = EMPTY;
         end
         TWO: if (pop) state_d = ONE;
         default: state_d = EMPTY;
      endcase
   end

   // Push with pop at ONE overwrites the head; the tail is only used from ONE to TWO.
   assign load_head = push && ((state_q == EMPTY) || (state_q == ONE && pop));
   assign load_tail = push && (state_q == ONE) && !pop;
   assign shift     = pop && (state_q == TWO);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= EMPTY;
         head_data <= '0;
         head_sel  <= '0;
         tail_data <= '0;
         tail_sel  <= '0;
      end else begin
         state_q <= state_d;
         if (load_head) begin
            head_data <= push_data;
            head_sel  <= grant;
         end else if (shift) begin
            head_data <= tail_data;
            head_sel  <= tail_sel;
         end
         if (load_tail) begin
            tail_data <= push_data;
            tail_sel  <= grant;
         end
      end
   end

   assign out_data = head_data;
   assign out_sel  = head_sel;

endmodule
